safe_sequencer: RTL
===================

SAFE_SEQUENCER -- requirements
Module: safe_sequencer

Interface
REQ-001 SHALL have parameter KEY, default 56'd3008192072309708 (56'h0AAFEF4BE2DBCC): the scrambled word that opens the safe.
REQ-002 SHALL have parameter MAX_FAILS, default 3: consecutive failed attempts that trigger lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 1024: lockout duration in clk cycles (range 1..65535).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  character offered.
REQ-007 in_data  input  7  character value.
REQ-008 in_ready  output  1  character accepted when in_valid&in_ready.
REQ-009 clear  input  1  synchronous abort / re-arm.
REQ-010 open_safe  output  1  registered; high while unlocked.
REQ-011 busy  output  1  high in CHECK or FAIL.
REQ-012 locked_out  output  1  high in LOCKOUT.
REQ-013 fail_count  output  4  consecutive failures, saturating at 15.

Function
REQ-014 States SHALL be COLLECT, CHECK, OPEN, FAIL, LOCKOUT; encoding free.
REQ-015 in_ready SHALL equal (state==COLLECT); accept = in_valid & in_ready & ~clear.
REQ-016 Slot register (3 bit) SHALL start at 0 and advance by 5 mod 8 per accept; in_data written to mem[slot]; write order 0,5,2,7,4,1,6,3.
REQ-017 Count register SHALL count accepts 0..7; 8th accept moves COLLECT->CHECK and resets slot and count to 0.
REQ-018 magic SHALL be {mem0,mem5,mem6,mem2,mem4,mem3,mem7,mem1} (56 bits, mem0 at MSB).
REQ-019 word SHALL be {magic[9:0], magic[41:22], magic[21:10], magic[55:42]}.
REQ-020 CHECK SHALL last exactly 1 cycle: word==KEY -> OPEN, else -> FAIL.
REQ-021 Latency: 8th accept at edge N -> open_safe high after edge N+2.
REQ-022 OPEN SHALL hold open_safe=1 and fail_count=0 until clear; then -> COLLECT, open_safe=0.
REQ-023 FAIL SHALL last 1 cycle, increment fail_count (saturating at 15), then -> COLLECT.
REQ-024 clear in COLLECT, CHECK or FAIL SHALL -> COLLECT, reset slot/count, discard the attempt, leave fail_count unchanged; clear with a handshake in the same cycle: clear wins, character dropped.
REQ-025 mem contents SHALL NOT be cleared between attempts; every attempt rewrites all 8 slots.
REQ-026 in_data SHALL be ignored when not accepted; in_valid held in non-COLLECT states SHALL NOT be accepted.

Reset
REQ-027 rst_n low SHALL asynchronously force state=COLLECT, slot=0, count=0, fail_count=0, open_safe=0, locked_out=0, busy=0, lockout timer=0; mem reset to 0.
REQ-028 Reset mid-attempt, in OPEN or in LOCKOUT SHALL abandon it fully; first accept after release writes slot 0.

Configuration
REQ-029 Macro SAFE_LOCKOUT_EN SHALL gate lockout logic.
REQ-030 With SAFE_LOCKOUT_EN: FAIL with incremented fail_count >= MAX_FAILS -> LOCKOUT; LOCKOUT holds in_ready=0, locked_out=1 for exactly LOCKOUT_CYCLES cycles, ignores clear, then -> COLLECT with fail_count=0.
REQ-031 Without SAFE_LOCKOUT_EN: no LOCKOUT state or timer, locked_out tied 0, FAIL always -> COLLECT.

Verification
REQ-032 Bytes 0x37,0x4C,0x6F,0x58,0x25,0x2A,0x5F,0x78 ("7LoX%*_x") -> busy high 1 cycle, open_safe=1 two edges after 8th accept, fail_count=0.
REQ-033 Same with last byte 0x79 -> FAIL, fail_count=1, in_ready=1 next cycle, open_safe stays 0.
REQ-034 Correct bytes with in_valid gaps and clear asserted with the 4th byte, then 8 correct bytes -> 4th byte dropped, second attempt opens, fail_count unchanged.
REQ-035 SAFE_LOCKOUT_EN, LOCKOUT_CYCLES=16: 3 wrong attempts -> locked_out=1, in_ready=0 for exactly 16 cycles, clear ignored, then fail_count=0, correct attempt opens.
REQ-036 rst_n pulsed low after 5 accepts, and again while OPEN -> all outputs 0 immediately; next 8 correct bytes open the safe.

Source files
------------

// File: rtl/safe_sequencer.sv
// Combination-lock sequencer: collects 8 scrambled characters and opens when they match KEY.
// Optional lockout after repeated failures is enabled by defining SAFE_LOCKOUT_EN.
module safe_sequencer #(
  parameter logic [55:0] KEY            = 56'h0AAFEF4BE2DBCC,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] in_data,
  output logic       in_ready,
  input  logic       clear,
  output logic       open_safe,
  output logic       busy,
  output logic       locked_out,
  output logic [3:0] fail_count
);

  localparam logic [2:0] COLLECT = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] OPEN    = 3'd2;
  localparam logic [2:0] FAIL    = 3'd3;
`ifdef SAFE_LOCKOUT_EN
  localparam logic [2:0] LOCKOUT = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  fail_q, fail_d;
  logic        open_q, open_d;
  logic [6:0]  mem_q [8];
  logic        accept;
  logic [3:0]  fail_inc;
  logic [55:0] magic;
  logic [55:0] word;
`ifdef SAFE_LOCKOUT_EN
  logic [15:0] timer_q, timer_d;
`else
  logic        unused_cfg;
  assign unused_cfg = ^{32'(MAX_FAILS), 32'(LOCKOUT_CYCLES)};
`endif

  assign in_ready   = (state_q == COLLECT);
  assign accept     = in_valid & in_ready & ~clear;
  assign busy       = (state_q == CHECK) || (state_q == FAIL);
  assign open_safe  = open_q;
  assign fail_count = fail_q;
`ifdef SAFE_LOCKOUT_EN
  assign locked_out = (state_q == LOCKOUT);
`else
  assign locked_out = 1'b0;
`endif

  assign fail_inc = (fail_q == 4'd15) ? 4'd15 : fail_q + 4'd1;
  assign magic    = {mem_q[0], mem_q[5], mem_q[6], mem_q[2],
                     mem_q[4], mem_q[3], mem_q[7], mem_q[1]};
  assign word     = {magic[9:0], magic[41:22], magic[21:10], magic[55:42]};

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    count_d = count_q;
    fail_d  = fail_q;
    open_d  = 1'b0;
`ifdef SAFE_LOCKOUT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      COLLECT: begin
        if (clear) begin
          slot_d  = 3'd0;
          count_d = 3'd0;
        end else if (accept) begin
          if (count_q == 3'd7) begin
            state_d = CHECK;
            slot_d  = 3'd0;
            count_d = 3'd0;
          end else begin
            slot_d  = slot_q + 3'd5;
            count_d = count_q + 3'd1;
          end
        end
      end
      CHECK: begin
        if (clear) begin
          state_d = COLLECT;
        end else if (word == KEY) begin
          state_d = OPEN;
          fail_d  = 4'd0;
        end else begin
          state_d = FAIL;
        end
      end
      OPEN: begin
        // open_safe drops on the same edge the state leaves OPEN
        if (clear) state_d = COLLECT;
        else       open_d  = 1'b1;
      end
      FAIL: begin
        state_d = COLLECT;
        if (!clear) begin
          fail_d = fail_inc;
`ifdef SAFE_LOCKOUT_EN
          if ({28'd0, fail_inc} >= MAX_FAILS) begin
            state_d = LOCKOUT;
            timer_d = 16'(LOCKOUT_CYCLES - 1);
          end
`endif
        end
      end
`ifdef SAFE_LOCKOUT_EN
      LOCKOUT: begin
        if (timer_q == 16'd0) begin
          state_d = COLLECT;
          fail_d  = 4'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`endif
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      slot_q  <= 3'd0;
      count_q <= 3'd0;
      fail_q  <= 4'd0;
      open_q  <= 1'b0;
      for (int i = 0; i < 8; i++) mem_q[i] <= 7'd0;
`ifdef SAFE_LOCKOUT_EN
      timer_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      count_q <= count_d;
      fail_q  <= fail_d;
      open_q  <= open_d;
      if (accept) mem_q[slot_q] <= in_data;
`ifdef SAFE_LOCKOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

endmodule
